mem_access_ctrl: RTL and testbench

Request-side controller for the single-port data memory (`MemReadWrite`). It accepts one load or store at a time from the datapath over a valid/ready handshake and sequences the memory's `en`/`wen`/`addr`/`din` strobes. It waits out the memory's read latency, registers `dout`, and returns a response over a second valid/ready handshake. It sits between the MIPS load/store stage and the memory and is the only driver of the memory's control inputs.

---
 rtl/mem_ctrl_pkg.sv | 16 +
 rtl/mem_access_ctrl.sv | 179 +++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared types and sizes for the data-memory controller and memory wrapper
// Contents: mem_ctrl_state_t FSM encoding, MEM_DEPTH / MEM_ADDR_W / MEM_DATA_W defaults.
package mem_ctrl_pkg;

    localparam int MEM_DEPTH  = 51200;
    localparam int MEM_ADDR_W = 16;
    localparam int MEM_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } mem_ctrl_state_t;

endpackage

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - single-outstanding load/store controller driving MemReadWrite
// Optional feature macro: MEM_ACCESS_BOUNDS_CHECK_EN (reject word addresses >= DEPTH without strobing memory).
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   req_valid/req_ready             request handshake; req_we/req_addr/req_wdata request fields
//   rsp_valid/rsp_ready             response handshake; rsp_rdata/rsp_err response fields
//   mem_en/mem_wen/mem_addr/mem_din memory strobes (registered), mem_dout memory read data
//   busy                            FSM is not IDLE
import mem_ctrl_pkg::*;

module mem_access_ctrl #(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DATA_W = MEM_DATA_W,
    parameter int DEPTH  = MEM_DEPTH,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              mem_en,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              busy
);

    // Elaboration guard: the latency counter is 2 bits wide and the address
    // space must cover every implemented word.
    if (RD_LAT < 1 || RD_LAT > 3 || DEPTH < 1 || DEPTH > (1 << ADDR_W)) begin : g_bad_cfg
        $error("mem_access_ctrl: illegal RD_LAT/DEPTH/ADDR_W combination");
    end

    // WAIT lasts RD_LAT cycles: the counter starts at RD_LAT-1 and the exit
    // happens on the cycle it reads zero.
    localparam logic [1:0] LAT_INIT = 2'(RD_LAT - 1);

    mem_ctrl_state_t   state_q, state_d;
    logic              we_q, we_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              req_ready_q, req_ready_d;
    logic              busy_q, busy_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_wen_q, mem_wen_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_din_q, mem_din_d;

`ifdef MEM_ACCESS_BOUNDS_CHECK_EN
    logic              rsp_err_q, rsp_err_d;
    logic              addr_oob;

    // Zero-extend before comparing so DEPTH = 2**ADDR_W cannot wrap.
    assign addr_oob = (32'(req_addr) >= 32'(DEPTH));
`endif

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        cnt_d       = cnt_q;
        rsp_rdata_d = rsp_rdata_q;
        mem_addr_d  = mem_addr_q;
        mem_din_d   = mem_din_q;
`ifdef MEM_ACCESS_BOUNDS_CHECK_EN
        rsp_err_d   = rsp_err_q;
`endif

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    rsp_rdata_d = '0;
`ifdef MEM_ACCESS_BOUNDS_CHECK_EN
                    rsp_err_d   = 1'b0;
                    if (addr_oob) begin
                        // Rejected: answer straight away, memory registers untouched.
                        rsp_err_d = 1'b1;
                        state_d   = RESP;
                    end else begin
`else
                    begin
`endif
                        state_d    = ACCESS;
                        we_d       = req_we;
                        mem_addr_d = req_addr;
                        mem_din_d  = req_wdata;
                    end
                end
            end
            ACCESS: begin
                if (we_q) begin
                    state_d = RESP;
                end else begin
                    state_d = WAIT;
                    cnt_d   = LAT_INIT;
                end
            end
            WAIT: begin
                if (cnt_q == 2'd0) begin
                    rsp_rdata_d = mem_dout;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered copies of the decode of the next state, so
        // they line up with the state they describe and have no input path.
        req_ready_d = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
        rsp_valid_d = (state_d == RESP);
        mem_en_d    = (state_d == ACCESS);
        mem_wen_d   = (state_d == ACCESS) && we_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            cnt_q       <= 2'd0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            mem_en_q    <= 1'b0;
            mem_wen_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_din_q   <= '0;
`ifdef MEM_ACCESS_BOUNDS_CHECK_EN
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            cnt_q       <= cnt_d;
            req_ready_q <= req_ready_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            mem_en_q    <= mem_en_d;
            mem_wen_q   <= mem_wen_d;
            mem_addr_q  <= mem_addr_d;
            mem_din_q   <= mem_din_d;
`ifdef MEM_ACCESS_BOUNDS_CHECK_EN
            rsp_err_q   <= rsp_err_d;
`endif
        end
    end

    assign req_ready = req_ready_q;
    assign busy      = busy_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_wen   = mem_wen_q;
    assign mem_addr  = mem_addr_q;
    assign mem_din   = mem_din_q;
`ifdef MEM_ACCESS_BOUNDS_CHECK_EN
    assign rsp_err   = rsp_err_q;
`else
    assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - self-checking bench for mem_access_ctrl with RD_LAT=1 and RD_LAT=3 instances
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_we    [2];
    logic [15:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_err   [2];
    logic        mem_en    [2];
    logic        mem_wen   [2];
    logic [15:0] mem_addr  [2];
    logic [31:0] mem_din   [2];
    logic [31:0] mem_dout  [2];
    logic        busy      [2];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 1 : 3;
        logic [31:0] mem  [0:65535];
        logic [31:0] pipe [0:2];

        // Memory model: synchronous read captured on an enabled edge, then
        // delayed so the data appears LAT edges after the strobe.
        always @(posedge clk) begin
            if (mem_en[g]) begin
                if (mem_wen[g]) mem[mem_addr[g]] <= mem_din[g];
                pipe[0] <= mem[mem_addr[g]];
            end
            pipe[1] <= pipe[0];
            pipe[2] <= pipe[1];
        end
        assign mem_dout[g] = pipe[LAT-1];

        mem_access_ctrl #(.RD_LAT(LAT)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .req_valid (req_valid[g]),
            .req_ready (req_ready[g]),
            .req_we    (req_we[g]),
            .req_addr  (req_addr[g]),
            .req_wdata (req_wdata[g]),
            .rsp_valid (rsp_valid[g]),
            .rsp_ready (rsp_ready[g]),
            .rsp_rdata (rsp_rdata[g]),
            .rsp_err   (rsp_err[g]),
            .mem_en    (mem_en[g]),
            .mem_wen   (mem_wen[g]),
            .mem_addr  (mem_addr[g]),
            .mem_din   (mem_din[g]),
            .mem_dout  (mem_dout[g]),
            .busy      (busy[g])
        );
    end

    typedef struct {
        logic        rst, valid, we;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic        rready;
        logic        rr, bsy, rv, err;
        logic [31:0] rd;
        logic        en, wen;
        logic [15:0] maddr;
        logic [31:0] mdin;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic v, input logic w, input logic [15:0] a,
                                input logic [31:0] wd, input logic rrdy,
                                input logic rr, input logic bsy, input logic rv, input logic err,
                                input logic [31:0] rd, input logic en, input logic wen,
                                input logic [15:0] ma, input logic [31:0] md);
        vec_t t;
        t.rst = r; t.valid = v; t.we = w; t.addr = a; t.wdata = wd; t.rready = rrdy;
        t.rr = rr; t.bsy = bsy; t.rv = rv; t.err = err; t.rd = rd;
        t.en = en; t.wen = wen; t.maddr = ma; t.mdin = md;
        vecs.push_back(t);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One request with rsp_ready high. lat = edges after the accept edge until
    // rsp_valid is seen (accept edge itself is 0); en_exp = mem_en samples seen.
    task automatic run_req(input int d, input logic we, input logic [15:0] addr, input logic [31:0] wd,
                           input int exp_lat, input logic exp_err, input logic [31:0] exp_rd,
                           input int exp_en, input string nm);
        int lat;
        int en_cnt;
        bit seen;
        req_valid[d] = 1'b1; req_we[d] = we; req_addr[d] = addr; req_wdata[d] = wd;
        rsp_ready[d] = 1'b1;
        tick();
        req_valid[d] = 1'b0;
        lat = 0; en_cnt = 0; seen = 1'b0;
        while (!seen && lat < 20) begin
            if (mem_en[d]) en_cnt++;
            if (rsp_valid[d]) seen = 1'b1;
            else begin
                tick();
                lat++;
            end
        end
        chk({nm, " latency"}, lat, exp_lat);
        chk({nm, " rsp_err"}, 32'(rsp_err[d]), 32'(exp_err));
        chk({nm, " rsp_rdata"}, rsp_rdata[d], exp_rd);
        chk({nm, " mem_en pulses"}, en_cnt, exp_en);
        tick();
        chk({nm, " back to idle"}, 32'(busy[d]), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0; req_we[d] = 1'b0; req_addr[d] = '0;
            req_wdata[d] = '0; rsp_ready[d] = 1'b1;
        end

        //   rst v  we addr   wdata         rrdy | rr bsy rv err rd            en wen maddr  mdin
        add(1, 0, 0, 16'd0, 32'h0,         1,     1, 0,  0, 0,  32'h0,        0, 0,  16'd0, 32'h0);
        add(0, 0, 0, 16'd0, 32'h0,         1,     1, 0,  0, 0,  32'h0,        0, 0,  16'd0, 32'h0);
        // store 0x4 @5, then load 5
        add(0, 1, 1, 16'd5, 32'h4,         1,     0, 1,  0, 0,  32'h0,        1, 1,  16'd5, 32'h4);
        add(0, 0, 0, 16'd0, 32'h0,         1,     0, 1,  1, 0,  32'h0,        0, 0,  16'd5, 32'h4);
        add(0, 0, 0, 16'd0, 32'h0,         1,     1, 0,  0, 0,  32'h0,        0, 0,  16'd5, 32'h4);
        add(0, 1, 0, 16'd5, 32'h0,         1,     0, 1,  0, 0,  32'h0,        1, 0,  16'd5, 32'h0);
        add(0, 0, 0, 16'd0, 32'h0,         1,     0, 1,  0, 0,  32'h0,        0, 0,  16'd5, 32'h0);
        add(0, 0, 0, 16'd0, 32'h0,         1,     0, 1,  1, 0,  32'h4,        0, 0,  16'd5, 32'h0);
        add(0, 0, 0, 16'd0, 32'h0,         1,     1, 0,  0, 0,  32'h4,        0, 0,  16'd5, 32'h0);
        // store 0x1 @0, load 0 held back-to-back
        add(0, 1, 1, 16'd0, 32'h1,         1,     0, 1,  0, 0,  32'h0,        1, 1,  16'd0, 32'h1);
        add(0, 1, 0, 16'd0, 32'h0,         1,     0, 1,  1, 0,  32'h0,        0, 0,  16'd0, 32'h1);
        add(0, 1, 0, 16'd0, 32'h0,         1,     1, 0,  0, 0,  32'h0,        0, 0,  16'd0, 32'h1);
        add(0, 1, 0, 16'd0, 32'h0,         1,     0, 1,  0, 0,  32'h0,        1, 0,  16'd0, 32'h0);
        add(0, 0, 0, 16'd0, 32'h0,         1,     0, 1,  0, 0,  32'h0,        0, 0,  16'd0, 32'h0);
        add(0, 0, 0, 16'd0, 32'h0,         1,     0, 1,  1, 0,  32'h1,        0, 0,  16'd0, 32'h0);
        add(0, 0, 0, 16'd0, 32'h0,         1,     1, 0,  0, 0,  32'h1,        0, 0,  16'd0, 32'h0);
        // store to the last in-range word
        add(0, 1, 1, 16'd51199, 32'hCAFE0001, 1,  0, 1,  0, 0,  32'h0,        1, 1,  16'd51199, 32'hCAFE0001);
        add(0, 0, 0, 16'd0, 32'h0,         1,     0, 1,  1, 0,  32'h0,        0, 0,  16'd51199, 32'hCAFE0001);
        add(0, 0, 0, 16'd0, 32'h0,         1,     1, 0,  0, 0,  32'h0,        0, 0,  16'd51199, 32'hCAFE0001);
        // load @2, reset during WAIT
        add(0, 1, 0, 16'd2, 32'h0,         1,     0, 1,  0, 0,  32'h0,        1, 0,  16'd2, 32'h0);
        add(0, 0, 0, 16'd0, 32'h0,         1,     0, 1,  0, 0,  32'h0,        0, 0,  16'd2, 32'h0);
        add(1, 0, 0, 16'd0, 32'h0,         1,     1, 0,  0, 0,  32'h0,        0, 0,  16'd0, 32'h0);
        add(0, 0, 0, 16'd0, 32'h0,         1,     1, 0,  0, 0,  32'h0,        0, 0,  16'd0, 32'h0);
        add(0, 0, 0, 16'd0, 32'h0,         1,     1, 0,  0, 0,  32'h0,        0, 0,  16'd0, 32'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            rst          = vecs[i].rst;
            req_valid[0] = vecs[i].valid;
            req_we[0]    = vecs[i].we;
            req_addr[0]  = vecs[i].addr;
            req_wdata[0] = vecs[i].wdata;
            rsp_ready[0] = vecs[i].rready;
            tick();
            chk($sformatf("v%0d req_ready", i), 32'(req_ready[0]), 32'(vecs[i].rr));
            chk($sformatf("v%0d busy", i),      32'(busy[0]),      32'(vecs[i].bsy));
            chk($sformatf("v%0d rsp_valid", i), 32'(rsp_valid[0]), 32'(vecs[i].rv));
            chk($sformatf("v%0d rsp_err", i),   32'(rsp_err[0]),   32'(vecs[i].err));
            chk($sformatf("v%0d rsp_rdata", i), rsp_rdata[0],      vecs[i].rd);
            chk($sformatf("v%0d mem_en", i),    32'(mem_en[0]),    32'(vecs[i].en));
            chk($sformatf("v%0d mem_wen", i),   32'(mem_wen[0]),   32'(vecs[i].wen));
            chk($sformatf("v%0d mem_addr", i),  32'(mem_addr[0]),  32'(vecs[i].maddr));
            chk($sformatf("v%0d mem_din", i),   mem_din[0],        vecs[i].mdin);
        end
        rst = 1'b0;

        // Back-pressure: response held for 10 cycles while a new request waits.
        req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 16'd5; req_wdata[0] = 32'h0;
        rsp_ready[0] = 1'b0;
        tick();
        req_valid[0] = 1'b0;
        tick();
        tick();
        chk("bp rsp_valid start", 32'(rsp_valid[0]), 32'd1);
        chk("bp rsp_rdata start", rsp_rdata[0], 32'h4);
        req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 16'd7; req_wdata[0] = 32'h77;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("bp%0d rsp_valid", i), 32'(rsp_valid[0]), 32'd1);
            chk($sformatf("bp%0d rsp_rdata", i), rsp_rdata[0], 32'h4);
            chk($sformatf("bp%0d req_ready", i), 32'(req_ready[0]), 32'd0);
            chk($sformatf("bp%0d mem_en", i), 32'(mem_en[0]), 32'd0);
        end
        rsp_ready[0] = 1'b1;
        tick();
        chk("bp handshake busy", 32'(busy[0]), 32'd0);
        chk("bp handshake mem_en", 32'(mem_en[0]), 32'd0);
        chk("bp handshake rsp_valid", 32'(rsp_valid[0]), 32'd0);
        tick();
        chk("bp accept mem_en", 32'(mem_en[0]), 32'd1);
        chk("bp accept mem_wen", 32'(mem_wen[0]), 32'd1);
        chk("bp accept mem_addr", 32'(mem_addr[0]), 32'd7);
        req_valid[0] = 1'b0;
        tick();
        chk("bp store rsp_valid", 32'(rsp_valid[0]), 32'd1);
        tick();
        chk("bp store idle", 32'(busy[0]), 32'd0);

        // Address bounds: DEPTH-1 is in range.
        run_req(0, 1'b0, 16'd51199, 32'h0, 2, 1'b0, 32'hCAFE0001, 1, "ld 51199");
`ifdef MEM_ACCESS_BOUNDS_CHECK_EN
        run_req(0, 1'b0, 16'd51201, 32'h0, 0, 1'b1, 32'h0, 0, "ld 51201 oob");
        run_req(0, 1'b0, 16'd51200, 32'h0, 0, 1'b1, 32'h0, 0, "ld 51200 oob");
        run_req(0, 1'b1, 16'd60000, 32'h5, 0, 1'b1, 32'h0, 0, "st 60000 oob");
        run_req(0, 1'b0, 16'd51199, 32'h0, 2, 1'b0, 32'hCAFE0001, 1, "ld 51199 after oob");
`else
        run_req(0, 1'b1, 16'd51201, 32'hBEEF0002, 1, 1'b0, 32'h0, 1, "st 51201 pass");
        run_req(0, 1'b0, 16'd51201, 32'h0, 2, 1'b0, 32'hBEEF0002, 1, "ld 51201 pass");
`endif

        // RD_LAT=3 instance: store still N+2, load at N+5.
        run_req(1, 1'b1, 16'd5, 32'h4, 1, 1'b0, 32'h0, 1, "lat3 st 5");
        run_req(1, 1'b0, 16'd5, 32'h0, 4, 1'b0, 32'h4, 1, "lat3 ld 5");
        run_req(1, 1'b1, 16'd9, 32'h900D, 1, 1'b0, 32'h0, 1, "lat3 st 9");
        run_req(1, 1'b0, 16'd9, 32'h0, 4, 1'b0, 32'h900D, 1, "lat3 ld 9");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
